regfile_arbiter: RTL

Shares the single register file (one write address, two read addresses, write on every clock edge) between two requesters: port A (the core datapath/sequencer) and port B (debug/host loader). Each cycle it arbitrates round-robin with optional bounded locking, drives the register-file address and write-data lines, and returns registered read data one cycle later. Because the register file writes unconditionally on every clock, the arbiter drives a hold write of the current contents in all idle, read-only and reset cycles.

---
 rtl/regfile_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares one register file (one write port, two read ports, written on
//   every clock edge) between requester A (core datapath) and requester B
//   (debug/host loader). Arbitration is round-robin with a bounded lock.
//   The lock lets a winner keep the grant for up to LOCK_MAX consecutive
//   cycles; after that the other requester is served once.
//   The register file writes unconditionally, so every idle, read-only or
//   reset cycle drives a hold write: the current contents of the write
//   address are read on the hold port and written back unchanged.
//
// Ports
//   clk, nReset                 clock (rising edge), async active-low reset
//   x_req, x_we, x_lock         per-port request, write enable, lock request
//   x_addr, x_wdata             per-port address and write data
//   x_gnt                       combinational grant for the current cycle
//   x_rvalid, x_rdata           registered read response, one cycle later
//   rf_waddr, rf_wdata          register-file write port
//   rf_raddr / rf_rdata         register-file read port 1 (requested data)
//   rf_haddr / rf_hdata         register-file read port 2 (hold-write data)
module regfile_arbiter #(
    parameter int n        = 8,
    parameter int AW       = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 a_req,
    input  logic                 b_req,
    input  logic                 a_we,
    input  logic                 b_we,
    input  logic                 a_lock,
    input  logic                 b_lock,
    input  logic [AW-1:0]        a_addr,
    input  logic [AW-1:0]        b_addr,
    input  logic signed [n-1:0]  a_wdata,
    input  logic signed [n-1:0]  b_wdata,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output logic                 a_rvalid,
    output logic                 b_rvalid,
    output logic signed [n-1:0]  a_rdata,
    output logic signed [n-1:0]  b_rdata,
    output logic [AW-1:0]        rf_waddr,
    output logic signed [n-1:0]  rf_wdata,
    output logic [AW-1:0]        rf_raddr,
    output logic [AW-1:0]        rf_haddr,
    input  logic signed [n-1:0]  rf_rdata,
    input  logic signed [n-1:0]  rf_hdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    localparam int            CW         = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    owner_e        owner_r;
    owner_e        owner_nxt_s;
    logic [CW-1:0] lock_cnt_r;
    logic [CW-1:0] lock_cnt_nxt_s;
    logic          prio_r;
    logic          prio_nxt_s;
    logic          a_win_s;
    logic          b_win_s;
    logic          forced_s;
    logic          win_lock_s;
    logic          a_rd_s;
    logic          b_rd_s;

    // Winner selection: live lock, then forced release, then single/priority.
    always_comb begin
        a_win_s  = 1'b0;
        b_win_s  = 1'b0;
        forced_s = 1'b0;
        if (!nReset) begin
            a_win_s  = 1'b0;
            b_win_s  = 1'b0;
            forced_s = 1'b0;
        end else begin
            // A saturated lock with the other side waiting must let go once.
            forced_s = ((owner_r == OWN_A) && (lock_cnt_r == LOCK_MAX_C) && b_req) ||
                       ((owner_r == OWN_B) && (lock_cnt_r == LOCK_MAX_C) && a_req);
            if ((owner_r == OWN_A) && a_req && (lock_cnt_r < LOCK_MAX_C)) begin
                a_win_s = 1'b1;
            end else if ((owner_r == OWN_B) && b_req && (lock_cnt_r < LOCK_MAX_C)) begin
                b_win_s = 1'b1;
            end else if (a_req && !b_req) begin
                a_win_s = 1'b1;
            end else if (b_req && !a_req) begin
                b_win_s = 1'b1;
            end else if (a_req && b_req) begin
                if ((owner_r == OWN_A) && forced_s) begin
                    b_win_s = 1'b1;
                end else if ((owner_r == OWN_B) && forced_s) begin
                    a_win_s = 1'b1;
                end else if (prio_r) begin
                    b_win_s = 1'b1;
                end else begin
                    a_win_s = 1'b1;
                end
            end else begin
                a_win_s = 1'b0;
                b_win_s = 1'b0;
            end
        end
    end

    assign a_gnt  = a_win_s;
    assign b_gnt  = b_win_s;
    assign a_rd_s = a_win_s && !a_we;
    assign b_rd_s = b_win_s && !b_we;

    // Next arbitration state: priority flips to the loser, lock bookkeeping.
    always_comb begin
        owner_nxt_s    = OWN_NONE;
        lock_cnt_nxt_s = '0;
        prio_nxt_s     = prio_r;
        win_lock_s     = 1'b0;
        if (a_win_s || b_win_s) begin
            // Winner A means B is preferred next time (prio 1), and vice versa.
            prio_nxt_s = a_win_s;
            if (a_win_s) begin
                win_lock_s = a_lock;
            end else begin
                win_lock_s = b_lock;
            end
            if (win_lock_s && !forced_s) begin
                owner_nxt_s = a_win_s ? OWN_A : OWN_B;
                // A change of owner starts a fresh run; the holder keeps counting.
                if (owner_nxt_s != owner_r) begin
                    lock_cnt_nxt_s = CNT_ONE;
                end else if (lock_cnt_r == LOCK_MAX_C) begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r + CNT_ONE;
                end
            end else begin
                owner_nxt_s    = OWN_NONE;
                lock_cnt_nxt_s = '0;
            end
        end else begin
            owner_nxt_s    = OWN_NONE;
            lock_cnt_nxt_s = '0;
        end
    end

    // Register-file drive; never uses rf_rdata so no loop through the file.
    always_comb begin
        rf_waddr = '0;
        rf_raddr = '0;
        rf_haddr = '0;
        rf_wdata = rf_hdata;
        if (a_win_s) begin
            rf_waddr = a_addr;
            rf_raddr = a_addr;
            rf_haddr = a_addr;
            if (a_we) begin
                rf_wdata = a_wdata;
            end else begin
                rf_wdata = rf_hdata;
            end
        end else if (b_win_s) begin
            rf_waddr = b_addr;
            rf_raddr = b_addr;
            rf_haddr = b_addr;
            if (b_we) begin
                rf_wdata = b_wdata;
            end else begin
                rf_wdata = rf_hdata;
            end
        end else begin
            rf_waddr = '0;
            rf_raddr = '0;
            rf_haddr = '0;
            rf_wdata = rf_hdata;
        end
    end

    // Arbitration state and registered read responses.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            owner_r    <= OWN_NONE;
            lock_cnt_r <= '0;
            prio_r     <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            owner_r    <= owner_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            prio_r     <= prio_nxt_s;
            a_rvalid   <= a_rd_s;
            b_rvalid   <= b_rd_s;
            if (a_rd_s) begin
                a_rdata <= rf_rdata;
            end
            if (b_rd_s) begin
                b_rdata <= rf_rdata;
            end
        end
    end

endmodule
